xfer_burst_sequencer: RTL and testbench

- Takes a transfer command (start word address, size in bytes) and splits it into word bursts for the memory-side master.
- Rounds the byte size up to whole words, using the same ceil-divide rule as get_word_count_for_size.
- No burst crosses a MAX_BURST_WORDS-aligned boundary.
- Sits between the DMA command queue and the bus master; one command in flight at a time.

---
 rtl/math_pkg.sv | 17 +
 rtl/xfer_pkg.sv | 35 +++
 rtl/burst_len_calc.sv | 27 ++
 rtl/xfer_burst_sequencer.sv | 132 +++++++++++++
 tb/tb_xfer_burst_sequencer.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/math_pkg.sv
// Shared elaboration-time math helpers used to size datapaths across the DMA blocks.
package math_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int get_word_count_for_size(input int size_bytes, input int word_bytes);
    return (size_bytes + word_bytes - 1) / word_bytes;
  endfunction

endpackage

// File: rtl/xfer_pkg.sv
// Types and width helpers shared by the transfer burst sequencers.
package xfer_pkg;
  import math_pkg::*;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  // Widest bus word the keep mask helper supports.
  localparam int KEEP_MAX_W = 64;

  function automatic int size_w(input int max_bytes);
    return clog2(max_bytes + 1);
  endfunction

  function automatic int len_w(input int max_burst_words);
    return clog2(max_burst_words + 1);
  endfunction

  function automatic int rem_w(input int max_bytes, input int word_bytes);
    return clog2(get_word_count_for_size(max_bytes, word_bytes) + 1);
  endfunction

  // A zero tail means the final word is full, so every byte lane is kept.
  function automatic logic [KEEP_MAX_W-1:0] keep_mask(input int tail, input int word_bytes);
    logic [KEEP_MAX_W-1:0] m;
    for (int i = 0; i < KEEP_MAX_W; i++) begin
      m[i] = (tail == 0) ? (i < word_bytes) : (i < tail);
    end
    return m;
  endfunction

endpackage

// File: rtl/burst_len_calc.sv
// Length of the next burst: limited by words remaining and by the distance to the
// next MAX_BURST_WORDS-aligned boundary.
module burst_len_calc #(
  parameter int MAX_BURST_WORDS = 16,
  parameter int AL_W            = 4,
  parameter int LEN_W           = 5,
  parameter int REM_W           = 10
) (
  input  logic [AL_W-1:0]  addr_lo,
  input  logic [REM_W-1:0] rem_words,
  output logic [LEN_W-1:0] burst_len,
  output logic             is_last
);

  localparam int CW = ((REM_W > LEN_W) ? REM_W : LEN_W) + 1;

  logic [CW-1:0] room;
  logic [CW-1:0] rem_ext;

  always_comb begin
    rem_ext   = CW'(rem_words);
    room      = CW'(MAX_BURST_WORDS) - CW'(addr_lo & AL_W'(MAX_BURST_WORDS - 1));
    is_last   = (rem_ext <= room);
    burst_len = is_last ? LEN_W'(rem_ext) : LEN_W'(room);
  end

endmodule

// File: rtl/xfer_burst_sequencer.sv
// Splits a (word address, byte size) transfer command into boundary-aligned word bursts
// for the bus master; one command in flight at a time.
module xfer_burst_sequencer
  import xfer_pkg::*;
#(
  parameter int WORD_BYTES      = 8,
  parameter int MAX_BYTES       = 4096,
  parameter int MAX_BURST_WORDS = 16,
  parameter int ADDR_W          = 32,
  parameter int SIZE_W          = size_w(MAX_BYTES),
  parameter int LEN_W           = len_w(MAX_BURST_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [SIZE_W-1:0]     cmd_size,
  output logic                  burst_valid,
  input  logic                  burst_ready,
  output logic [ADDR_W-1:0]     burst_addr,
  output logic [LEN_W-1:0]      burst_len,
  output logic                  burst_last,
  output logic [WORD_BYTES-1:0] burst_keep,
  output logic                  done,
  output logic                  zero_err,
  output logic                  busy
);

  localparam int REM_W    = rem_w(MAX_BYTES, WORD_BYTES);
  localparam int WB_SHIFT = $clog2(WORD_BYTES);
  localparam int TAIL_W   = (WB_SHIFT > 0) ? WB_SHIFT : 1;
  localparam int AL_W     = (MAX_BURST_WORDS > 1) ? $clog2(MAX_BURST_WORDS) : 1;
  localparam logic [SIZE_W-1:0] MAX_SIZE = SIZE_W'(MAX_BYTES);

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [REM_W-1:0]  rem_words;
  logic [TAIL_W-1:0] tail_q;
  logic              zero_q;

  logic              accept;
  logic              advance;
  logic              use_cmd;
  logic [TAIL_W-1:0] cmd_tail;
  logic [TAIL_W-1:0] nxt_tail;
  logic [REM_W-1:0]  cmd_words;
  logic [REM_W-1:0]  nxt_rem;
  logic [ADDR_W-1:0] nxt_addr;
  logic [LEN_W-1:0]  calc_len;
  logic              calc_last;

  // FINISH also accepts, so a new command can land in the same cycle as done.
  assign cmd_ready   = (state != ST_ISSUE);
  assign burst_valid = (state == ST_ISSUE);
  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_FINISH);
  assign zero_err    = done && zero_q;
  assign burst_addr  = cur_addr;

  assign accept  = cmd_valid && cmd_ready;
  assign advance = burst_valid && burst_ready;
  assign use_cmd = (state != ST_ISSUE);

  // Ceil-divide by a power-of-two word size: whole words plus one for a partial tail.
  assign cmd_tail  = cmd_size[TAIL_W-1:0] & TAIL_W'(WORD_BYTES - 1);
  assign cmd_words = REM_W'(cmd_size >> WB_SHIFT) + REM_W'(cmd_tail != '0);

  // The next descriptor is computed from the command on accept, or from the
  // current descriptor on handshake, so it is registered with no extra bubble.
  assign nxt_addr = use_cmd ? cmd_addr  : cur_addr + ADDR_W'(burst_len);
  assign nxt_rem  = use_cmd ? cmd_words : rem_words - REM_W'(burst_len);
  assign nxt_tail = use_cmd ? cmd_tail  : tail_q;

  burst_len_calc #(
    .MAX_BURST_WORDS (MAX_BURST_WORDS),
    .AL_W            (AL_W),
    .LEN_W           (LEN_W),
    .REM_W           (REM_W)
  ) u_len_calc (
    .addr_lo   (nxt_addr[AL_W-1:0]),
    .rem_words (nxt_rem),
    .burst_len (calc_len),
    .is_last   (calc_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cur_addr   <= '0;
      rem_words  <= '0;
      tail_q     <= '0;
      zero_q     <= 1'b0;
      burst_len  <= '0;
      burst_last <= 1'b0;
      burst_keep <= '0;
    end else if (accept) begin
      zero_q <= (cmd_size == '0);
      tail_q <= cmd_tail;
      if (cmd_size == '0) begin
        state <= ST_FINISH;
      end else begin
        state      <= ST_ISSUE;
        cur_addr   <= nxt_addr;
        rem_words  <= nxt_rem;
        burst_len  <= calc_len;
        burst_last <= calc_last;
        burst_keep <= calc_last ? WORD_BYTES'(keep_mask(int'(nxt_tail), WORD_BYTES)) : '1;
      end
    end else if (advance) begin
      if (burst_last) begin
        state <= ST_FINISH;
      end else begin
        cur_addr   <= nxt_addr;
        rem_words  <= nxt_rem;
        burst_len  <= calc_len;
        burst_last <= calc_last;
        burst_keep <= calc_last ? WORD_BYTES'(keep_mask(int'(nxt_tail), WORD_BYTES)) : '1;
      end
    end else if (state == ST_FINISH) begin
      state <= ST_IDLE;
    end
  end

  // Oversized commands are illegal; flag them in simulation.
  always_ff @(posedge clk) begin
    if (rst_n && accept) begin
      assert (cmd_size <= MAX_SIZE);
    end
  end

endmodule

// File: tb/tb_xfer_burst_sequencer.sv
// Directed bench for xfer_burst_sequencer with WORD_BYTES=8, MAX_BURST_WORDS=16.
module tb_xfer_burst_sequencer;

  localparam int WORD_BYTES      = 8;
  localparam int MAX_BYTES       = 4096;
  localparam int MAX_BURST_WORDS = 16;
  localparam int ADDR_W          = 32;
  localparam int SIZE_W          = 13;
  localparam int LEN_W           = 5;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_W-1:0]     cmd_addr;
  logic [SIZE_W-1:0]     cmd_size;
  logic                  burst_valid;
  logic                  burst_ready;
  logic [ADDR_W-1:0]     burst_addr;
  logic [LEN_W-1:0]      burst_len;
  logic                  burst_last;
  logic [WORD_BYTES-1:0] burst_keep;
  logic                  done;
  logic                  zero_err;
  logic                  busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  xfer_burst_sequencer #(
    .WORD_BYTES      (WORD_BYTES),
    .MAX_BYTES       (MAX_BYTES),
    .MAX_BURST_WORDS (MAX_BURST_WORDS),
    .ADDR_W          (ADDR_W),
    .SIZE_W          (SIZE_W),
    .LEN_W           (LEN_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_size    (cmd_size),
    .burst_valid (burst_valid),
    .burst_ready (burst_ready),
    .burst_addr  (burst_addr),
    .burst_len   (burst_len),
    .burst_last  (burst_last),
    .burst_keep  (burst_keep),
    .done        (done),
    .zero_err    (zero_err),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_burst_valid"}, burst_valid, 0);
    check({tag, "_burst_addr"}, burst_addr, 0);
    check({tag, "_burst_len"}, burst_len, 0);
    check({tag, "_burst_last"}, burst_last, 0);
    check({tag, "_burst_keep"}, burst_keep, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_zero_err"}, zero_err, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // Called at a falling edge; returns at the falling edge after the handshake edge.
  task automatic send_cmd(input logic [ADDR_W-1:0] addr, input logic [SIZE_W-1:0] size);
    int waited;
    waited = 0;
    while (!cmd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_size  = size;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_addr  = 32'hDEAD_BEEF;
    cmd_size  = 13'h0FF;
  endtask

  // Descriptor must be present immediately; held stable for 'stall' cycles, then taken.
  task automatic expect_burst(input string tag, input logic [ADDR_W-1:0] addr,
                              input logic [LEN_W-1:0] len, input logic last,
                              input logic [WORD_BYTES-1:0] keep, input int stall);
    for (int s = 0; s <= stall; s++) begin
      check({tag, "_valid"}, burst_valid, 1);
      check({tag, "_addr"}, burst_addr, addr);
      check({tag, "_len"}, burst_len, len);
      check({tag, "_last"}, burst_last, last);
      check({tag, "_keep"}, burst_keep, keep);
      check({tag, "_no_done"}, done, 0);
      burst_ready = (s == stall);
      @(negedge clk);
    end
    burst_ready = 1'b0;
  endtask

  task automatic expect_done(input string tag, input logic zero);
    check({tag, "_done"}, done, 1);
    check({tag, "_zero_err"}, zero_err, zero);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_burst_valid"}, burst_valid, 0);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_zero_err_pulse"}, zero_err, 0);
    check({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    rst_n       = 1'b1;
    cmd_valid   = 1'b0;
    cmd_addr    = '0;
    cmd_size    = '0;
    burst_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst0");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("idle0");

    // Single aligned full burst.
    send_cmd(32'd0, 13'd128);
    check("c1_busy", busy, 1);
    check("c1_cmd_ready_low", cmd_ready, 0);
    expect_burst("c1b0", 32'd0, 5'd16, 1'b1, 8'hFF, 0);
    expect_done("c1", 1'b0);

    // Unaligned start, partial final word.
    send_cmd(32'd10, 13'd100);
    expect_burst("c2b0", 32'd10, 5'd6, 1'b0, 8'hFF, 0);
    expect_burst("c2b1", 32'd16, 5'd7, 1'b1, 8'h0F, 0);
    expect_done("c2", 1'b0);

    // Zero-size command.
    send_cmd(32'd5, 13'd0);
    expect_done("c3", 1'b1);

    // Maximum size from an unaligned address.
    send_cmd(32'd3, 13'd4096);
    expect_burst("c4b0", 32'd3, 5'd13, 1'b0, 8'hFF, 0);
    for (int k = 1; k <= 31; k++) begin
      expect_burst($sformatf("c4b%0d", k), 32'(16 * k), 5'd16, 1'b0, 8'hFF, 0);
    end
    expect_burst("c4b32", 32'd512, 5'd3, 1'b1, 8'hFF, 0);
    expect_done("c4", 1'b0);

    // Back-pressure: descriptors must hold while burst_ready is low.
    send_cmd(32'd10, 13'd100);
    expect_burst("c5b0", 32'd10, 5'd6, 1'b0, 8'hFF, 5);
    expect_burst("c5b1", 32'd16, 5'd7, 1'b1, 8'h0F, 5);
    expect_done("c5", 1'b0);

    // Asynchronous reset during the second burst of a long command.
    send_cmd(32'd3, 13'd4096);
    expect_burst("c6b0", 32'd3, 5'd13, 1'b0, 8'hFF, 0);
    check("c6b1_valid", burst_valid, 1);
    check("c6b1_addr", burst_addr, 32'd16);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("c6_async");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("c6_hold_done", done, 0);
      check("c6_hold_valid", burst_valid, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("c6_post");

    send_cmd(32'd0, 13'd128);
    expect_burst("c7b0", 32'd0, 5'd16, 1'b1, 8'hFF, 0);
    expect_done("c7", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
